mem_arbiter: RTL and testbench

//  Shares one multi-cycle main memory (memory4c, pipelined, fixed read latency) between the
//  I-cache miss handler, the D-cache miss handler and D-side write-through stores. Grants one

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_beat_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM states and block owner codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Beat up-counter with synchronous clear and count enable; clear wins over enable.
module mem_arbiter_beat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: grants stores, D-fills and I-fills one at a time, issues
// back-to-back fill beats and steers returning words to the owning cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     d_req,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic                     d_wr_req,
  input  logic [ADDR_W-1:0]        d_wr_addr,
  input  logic [DATA_W-1:0]        d_wr_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid,
  output logic [DATA_W-1:0]        fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_done,
  output logic                     d_done,
  output logic                     wr_done,
  output logic                     busy
);

  localparam int WI     = $clog2(WORDS);
  localparam int CW     = WI + 1;
  localparam int BASE_W = ADDR_W - WI - 1;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [CW-1:0]       issue_cnt, recv_cnt;
  logic                issue_en, recv_en, cnt_clr;

  // Word offset and byte-select bits of the miss address are regenerated per beat.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{i_addr[WI:0], d_addr[WI:0]};

  // Counters only run during a fill and sit at zero everywhere else.
  assign cnt_clr = (state_q != ST_FILL);
  assign recv_en = (state_q == ST_FILL) && mem_rvalid;

  mem_arbiter_beat_counter #(.W(CW)) u_issue_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(issue_en), .cnt_o(issue_cnt)
  );

  mem_arbiter_beat_counter #(.W(CW)) u_recv_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(recv_en), .cnt_o(recv_cnt)
  );

  // State, owner and block base registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_D;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
    end
  end

  // Grant, beat issue and completion sequencing.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue_en  = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    wr_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_WRITE;
        end else if (d_req) begin
          state_d = ST_FILL;
          owner_d = OWN_D;
          base_d  = d_addr[ADDR_W-1:WI+1];
        end else if (i_req) begin
          state_d = ST_FILL;
          owner_d = OWN_I;
          base_d  = i_addr[ADDR_W-1:WI+1];
        end
      end
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        wr_done   = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_FILL: begin
        if (issue_cnt < CW'(WORDS)) begin
          mem_en   = 1'b1;
          mem_addr = {base_q, issue_cnt[WI-1:0], 1'b0};
          issue_en = 1'b1;
        end
        if (mem_rvalid && (recv_cnt == CW'(WORDS - 1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Returned words pass straight through to whichever cache owns the fill.
  assign fill_data = mem_rdata;
  assign fill_word = recv_cnt[WI-1:0];
  assign i_fill_we = recv_en && (owner_q == OWN_I);
  assign d_fill_we = recv_en && (owner_q == OWN_D);
  assign busy      = (state_q != ST_IDLE);

  // A fixed-latency memory never has more than MEM_LAT beats outstanding.
  a_inflight: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_FILL) |-> (int'(issue_cnt) - int'(recv_cnt) <= MEM_LAT));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory model plus a transaction-level
// schedule model that predicts every cycle of each scenario.
module tb_mem_arbiter;
  localparam int ADDR_W = 16, DATA_W = 16, WORDS = 8, MEM_LAT = 4;
  localparam int WIN = 96;
  typedef logic [58:0] tr_t;

  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 0, d_req = 0, d_wr_req = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wr_addr = 0, d_wr_data = 0;
  logic mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0] fill_word;
  logic i_fill_we, d_fill_we, i_done, d_done, wr_done, busy;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .fill_data(fill_data),
    .fill_word(fill_word), .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done), .wr_done(wr_done), .busy(busy));

  // ---------------- memory model: contents are a keyed hash of the address
  logic [15:0] key = 16'h5A3C;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ key;
  endfunction

  logic        pv [MEM_LAT];
  logic [15:0] pd [MEM_LAT];
  logic        stray_v = 0;
  logic [15:0] stray_d = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MEM_LAT; k++) begin pv[k] <= 1'b0; pd[k] <= '0; end
    end else begin
      pv[0] <= mem_en && !mem_wr;
      pd[0] <= mem_word(mem_addr);
      for (int k = 1; k < MEM_LAT; k++) begin pv[k] <= pv[k-1]; pd[k] <= pd[k-1]; end
    end
  end

  assign mem_rvalid = pv[MEM_LAT-1] | stray_v;
  assign mem_rdata  = stray_v ? stray_d : (pv[MEM_LAT-1] ? pd[MEM_LAT-1] : 16'h0);

  // ---------------- scenario description and expected schedule
  int arr_wr, arr_d, arr_i;
  logic [15:0] a_wr, wd, a_d, a_i;
  int drop_wr, drop_d, drop_i, grant_d, grant_i, end_cyc;
  bit          e_en [WIN], e_wr [WIN], e_busy [WIN];
  logic [15:0] e_addr [WIN], e_wdata [WIN], e_data [WIN];
  logic [1:0]  e_fw [WIN];     // {d, i}
  logic [2:0]  e_word [WIN];
  logic [2:0]  e_done [WIN];   // {wr, d, i}
  tr_t exp_v [WIN], obs_v [WIN];

  task automatic sched_fill(input int t, input bit own_d, input logic [15:0] addr);
    logic [15:0] base;
    base = addr & ~16'(2 * WORDS - 1);
    for (int k = 0; k < WORDS; k++) begin
      e_en[t+1+k]             = 1'b1;
      e_addr[t+1+k]           = base + 16'(2 * k);
      e_fw[t+1+MEM_LAT+k]     = own_d ? 2'b10 : 2'b01;
      e_word[t+1+MEM_LAT+k]   = 3'(k);
      e_data[t+1+MEM_LAT+k]   = mem_word(base + 16'(2 * k));
    end
    e_done[t+WORDS+MEM_LAT+1] = own_d ? 3'b010 : 3'b001;
    for (int c = t + 1; c <= t + WORDS + MEM_LAT + 1; c++) e_busy[c] = 1'b1;
  endtask

  // Serve pending requests in priority order, one whole transaction at a time.
  task automatic build_model();
    int t;
    bit sw, sd, si;
    for (int c = 0; c < WIN; c++) begin
      e_en[c] = 0; e_wr[c] = 0; e_busy[c] = 0; e_addr[c] = 0; e_wdata[c] = 0;
      e_data[c] = 0; e_fw[c] = 0; e_word[c] = 0; e_done[c] = 0;
    end
    drop_wr = -100; drop_d = -100; drop_i = -100; grant_d = -100; grant_i = -100;
    t = 0; sw = (arr_wr < 0); sd = (arr_d < 0); si = (arr_i < 0);
    while (!(sw && sd && si)) begin
      if (!sw && arr_wr <= t) begin
        e_en[t+1] = 1; e_wr[t+1] = 1; e_addr[t+1] = a_wr; e_wdata[t+1] = wd;
        e_done[t+1] = 3'b100; e_busy[t+1] = 1;
        drop_wr = t + 1; sw = 1; t += 2;
      end else if (!sd && arr_d <= t) begin
        sched_fill(t, 1'b1, a_d);
        grant_d = t; drop_d = t + WORDS + MEM_LAT + 1; sd = 1; t += WORDS + MEM_LAT + 2;
      end else if (!si && arr_i <= t) begin
        sched_fill(t, 1'b0, a_i);
        grant_i = t; drop_i = t + WORDS + MEM_LAT + 1; si = 1; t += WORDS + MEM_LAT + 2;
      end else begin
        t++;
      end
    end
    end_cyc = t + 2;
    for (int c = 0; c < WIN; c++)
      exp_v[c] = {e_en[c], e_wr[c], e_addr[c], e_wdata[c], e_fw[c], e_word[c], e_data[c],
                  e_done[c], e_busy[c]};
  endtask

  function automatic tr_t pack_obs();
    logic fw;
    fw = i_fill_we | d_fill_we;
    return {mem_en, mem_wr, mem_en ? mem_addr : 16'h0, mem_wr ? mem_wdata : 16'h0,
            d_fill_we, i_fill_we, fw ? fill_word : 3'h0, fw ? fill_data : 16'h0,
            wr_done, d_done, i_done, busy};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one scenario starting in the current (idle) cycle and record every cycle.
  task automatic drive_scn();
    build_model();
    for (int c = 0; c <= end_cyc; c++) begin
      obs_v[c] = pack_obs();
      if (c == arr_wr) begin d_wr_req = 1; d_wr_addr = a_wr; d_wr_data = wd; end
      if (c == arr_d)  begin d_req = 1; d_addr = a_d; end
      if (c == arr_i)  begin i_req = 1; i_addr = a_i; end
      if (c == grant_d + 3) d_addr = 16'($urandom);
      if (c == grant_i + 3) i_addr = 16'($urandom);
      if (c == drop_wr) begin d_wr_req = 0; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom); end
      if (c == drop_d)  begin d_req = 0; d_addr = 16'($urandom); end
      if (c == drop_i)  begin i_req = 0; i_addr = 16'($urandom); end
      step();
    end
  endtask

  task automatic no_req();
    arr_wr = -1; arr_d = -1; arr_i = -1;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1; i_req = 1; d_req = 1; d_wr_req = 1; d_addr = 16'h1234;
    step(); step(); step();
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_hold busy=%b exp 0", busy); end
    i_req = 0; d_req = 0; d_wr_req = 0;
    step();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we, d_fill_we,
         i_done, d_done, wr_done, busy} !== '0) begin
      errs++; $display("FAIL reset_outputs en=%b wr=%b addr=%h busy=%b exp all 0",
                       mem_en, mem_wr, mem_addr, busy);
    end
    rst = 0;
    step();
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errs++; $display("FAIL reset_release busy=%b en=%b exp 0 0", busy, mem_en);
    end
  endtask

  task automatic test_write();
    no_req(); arr_wr = 0; a_wr = 16'h0040; wd = 16'hBEEF;
    drive_scn();
    for (int c = 0; c <= end_cyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin errs++; $display("FAIL write cyc=%0d got=%h exp=%h", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_fill_i();
    no_req(); arr_i = 0; a_i = 16'h0136;
    drive_scn();
    for (int c = 0; c <= end_cyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin errs++; $display("FAIL fill_i cyc=%0d got=%h exp=%h", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_simul_id();
    no_req(); arr_i = 0; a_i = 16'h0200; arr_d = 0; a_d = 16'h1000;
    drive_scn();
    for (int c = 0; c <= end_cyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin errs++; $display("FAIL simul_id cyc=%0d got=%h exp=%h", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_wr_d_mid();
    no_req(); arr_wr = 0; a_wr = 16'h2468; wd = 16'($urandom);
    arr_d = 0; a_d = 16'h3000; arr_i = 6; a_i = 16'h0ABC;
    drive_scn();
    for (int c = 0; c <= end_cyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin errs++; $display("FAIL wr_d_mid cyc=%0d got=%h exp=%h", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_reset_midfill();
    i_req = 1; i_addr = 16'h0136;
    for (int c = 0; c < 6; c++) step();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h013A) begin
      errs++; $display("FAIL rst_mid_pre en=%b addr=%h exp 1 013a", mem_en, mem_addr);
    end
    rst = 1; i_req = 0;
    step();
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we, d_fill_we,
         i_done, d_done, wr_done, busy} !== '0) begin
      errs++; $display("FAIL rst_mid_outputs en=%b we=%b done=%b busy=%b exp all 0",
                       mem_en, i_fill_we, i_done, busy);
    end
    rst = 0;
    step();
    checks++;
    if (busy !== 1'b0 || i_done !== 1'b0 || i_fill_we !== 1'b0) begin
      errs++; $display("FAIL rst_mid_after busy=%b done=%b we=%b exp 0 0 0", busy, i_done, i_fill_we);
    end
    no_req(); arr_i = 0; a_i = 16'h0356;
    drive_scn();
    for (int c = 0; c <= end_cyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c]) begin errs++; $display("FAIL rst_refill cyc=%0d got=%h exp=%h", c, obs_v[c], exp_v[c]); end
    end
  endtask

  task automatic test_stray_rvalid();
    stray_v = 1; stray_d = 16'hC0DE;
    #1;
    checks++;
    if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL stray_we i_we=%b d_we=%b busy=%b exp 0 0 0", i_fill_we, d_fill_we, busy);
    end
    step();
    stray_v = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
      errs++; $display("FAIL stray_state busy=%b en=%b exp 0 0", busy, mem_en);
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      arr_wr = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
      arr_d  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
      arr_i  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
      if (arr_wr < 0 && arr_d < 0 && arr_i < 0) arr_i = 0;
      a_wr = 16'($urandom); wd = 16'($urandom); a_d = 16'($urandom); a_i = 16'($urandom);
      drive_scn();
      for (int c = 0; c <= end_cyc; c++) begin
        checks++;
        if (obs_v[c] !== exp_v[c]) begin errs++; $display("FAIL random%0d cyc=%0d got=%h exp=%h", n, c, obs_v[c], exp_v[c]); end
      end
    end
  endtask

  initial begin
    key = 16'($urandom);
    #1;
    test_reset();
    test_write();
    test_fill_i();
    test_simul_id();
    test_wr_d_mid();
    test_reset_midfill();
    test_stray_rvalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog");
  end

endmodule
